// File: rtl/snake_body_streamer_pkg.sv
// Shared types and tile helpers for the snake body streamer.
// Directions are 2-bit codes; reversing a heading only flips bit 0.
package snake_body_streamer_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } tile_t;

  localparam int GAME_WIDTH  = 18;
  localparam int GAME_HEIGHT = 13;
  localparam logic [4:0] WALL_X = 5'(GAME_WIDTH + 1);
  localparam logic [3:0] WALL_Y = 4'(GAME_HEIGHT + 1);

  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  // Border tiles (0 and WIDTH+1 / HEIGHT+1) are representable, so no wrap is needed.
  function automatic tile_t tile_step(input logic [4:0] x, input logic [3:0] y, input dir_t d);
    tile_t t;
    t.x = x;
    t.y = y;
    case (d)
      DIR_RIGHT: t.x = x + 5'd1;
      DIR_LEFT:  t.x = x - 5'd1;
      DIR_DOWN:  t.y = y + 4'd1;
      DIR_UP:    t.y = y - 4'd1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/snake_dir_ring.sv
// Ring of per-segment directions: one synchronous write port, one asynchronous read port.
// Each cell resets to its initial-body value so the snake is valid straight out of reset.
module snake_dir_ring
  import snake_body_streamer_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  dir_t          wdata,
  input  logic [AW-1:0] raddr,
  output dir_t          rdata
);

  logic [1:0] cells [MAX_LEN];

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cell
      localparam dir_t RST_VAL = (gi < INIT_LEN - 1) ? DIR_LEFT : DIR_RIGHT;
      dir_t cell_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cell_reg <= RST_VAL;
        end else if (we && (waddr == AW'(gi))) begin
          cell_reg <= wdata;
        end
      end

      assign cells[gi] = cell_reg;
    end
  endgenerate

  assign rdata = dir_t'(cells[raddr]);

endmodule

// File: rtl/snake_body_streamer.sv
// Owns the snake body and streams it head-to-tail, one segment per clock, forever.
// A latched move is checked against one full pass of the stream, then applied in a one-cycle UPDATE.
module snake_body_streamer
  import snake_body_streamer_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 4,
  parameter int INIT_Y   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_valid,
  input  logic [1:0] step_dir,
  input  logic       step_grow,
  output logic       step_ready,
  output logic [4:0] head_x,
  output logic [3:0] head_y,
  output logic [5:0] length,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic [1:0] snake_dir,
  output logic       snake_first,
  output logic       snake_last,
  output logic       snake_valid,
  output logic       failure,
  output logic       success
);

  localparam int AW = $clog2(MAX_LEN);
  localparam tile_t INIT_HEAD = '{x: 5'(INIT_X), y: 4'(INIT_Y)};

  state_t        state_reg, state_next;
  tile_t         head_reg, cur_reg, nh;
  logic [5:0]    len_reg, k_reg;
  logic [AW-1:0] head_ptr_reg, rd_addr, wr_addr;
  dir_t          seg_dir, eff_dir, pdir_reg, wr_dir;

  logic       pend_reg, armed_reg, pgrow_reg, hit_reg;
  logic       ready_reg, failure_reg, success_reg;
  logic [4:0] sx_reg;
  logic [3:0] sy_reg;
  dir_t       sdir_reg;
  logic       sfirst_reg, slast_reg, svalid_reg;

  logic is_first, is_last, accept, arm_now, seg_hit, wall, illegal;
  logic emit, do_update, move_ok;

  snake_dir_ring #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) u_ring (
    .clk   (clk),
    .rst   (rst),
    .we    (move_ok),
    .waddr (wr_addr),
    .wdata (wr_dir),
    .raddr (rd_addr),
    .rdata (seg_dir)
  );

  assign rd_addr  = head_ptr_reg + k_reg[AW-1:0];
  assign wr_addr  = head_ptr_reg - AW'(1);
  assign wr_dir   = dir_reverse(pdir_reg);
  assign is_first = (k_reg == 6'd0);
  assign is_last  = (k_reg == len_reg - 6'd1);
  assign accept   = step_valid && ready_reg;

  // The check pass begins on the first head emission seen with a move already latched;
  // at that moment the ring read returns the head's own direction, used for reversal.
  assign arm_now = (state_reg == ST_STREAM) && is_first && pend_reg && !armed_reg;
  assign eff_dir = (pdir_reg == seg_dir) ? dir_reverse(seg_dir) : pdir_reg;

  assign nh      = tile_step(head_reg.x, head_reg.y, pdir_reg);
  assign seg_hit = armed_reg && !is_first && (cur_reg == nh) && !(is_last && !pgrow_reg);
  assign wall    = (nh.x == 5'd0) || (nh.x == WALL_X) || (nh.y == 4'd0) || (nh.y == WALL_Y);
  assign illegal = hit_reg || wall;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_STREAM;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STREAM: if (is_last && armed_reg) state_next = ST_UPDATE;
      ST_UPDATE: state_next = ST_STREAM;
    endcase
  end

  always_comb begin
    emit      = (state_reg == ST_STREAM);
    do_update = (state_reg == ST_UPDATE);
    move_ok   = do_update && !illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= INIT_HEAD;
      cur_reg      <= INIT_HEAD;
      len_reg      <= 6'(INIT_LEN);
      k_reg        <= 6'd0;
      head_ptr_reg <= '0;
      pend_reg     <= 1'b0;
      armed_reg    <= 1'b0;
      pdir_reg     <= DIR_RIGHT;
      pgrow_reg    <= 1'b0;
      hit_reg      <= 1'b0;
      ready_reg    <= 1'b1;
      failure_reg  <= 1'b0;
      success_reg  <= 1'b0;
      sx_reg       <= 5'd0;
      sy_reg       <= 4'd0;
      sdir_reg     <= DIR_RIGHT;
      sfirst_reg   <= 1'b0;
      slast_reg    <= 1'b0;
      svalid_reg   <= 1'b0;
    end else begin
      if (accept) begin
        pend_reg  <= 1'b1;
        pdir_reg  <= dir_t'(step_dir);
        pgrow_reg <= step_grow;
        ready_reg <= 1'b0;
      end

      if (emit) begin
        sx_reg     <= cur_reg.x;
        sy_reg     <= cur_reg.y;
        sdir_reg   <= seg_dir;
        sfirst_reg <= is_first;
        slast_reg  <= is_last;
        svalid_reg <= 1'b1;
        if (is_last) begin
          k_reg   <= 6'd0;
          cur_reg <= head_reg;
        end else begin
          k_reg   <= k_reg + 6'd1;
          cur_reg <= tile_step(cur_reg.x, cur_reg.y, seg_dir);
        end
        if (arm_now) begin
          armed_reg <= 1'b1;
          pdir_reg  <= eff_dir;
          hit_reg   <= 1'b0;
        end else if (armed_reg) begin
          hit_reg <= hit_reg || seg_hit;
        end
      end

      if (do_update) begin
        svalid_reg <= 1'b0;
        sfirst_reg <= 1'b0;
        slast_reg  <= 1'b0;
        pend_reg   <= 1'b0;
        armed_reg  <= 1'b0;
        hit_reg    <= 1'b0;
        if (illegal) begin
          failure_reg <= 1'b1;
        end else begin
          head_ptr_reg <= wr_addr;
          head_reg     <= nh;
          cur_reg      <= nh;
          if (pgrow_reg && (len_reg < 6'(MAX_LEN))) begin
            len_reg <= len_reg + 6'd1;
            if (len_reg == 6'(MAX_LEN - 1)) success_reg <= 1'b1;
          end
          ready_reg <= !(pgrow_reg && (len_reg == 6'(MAX_LEN - 1)));
        end
      end
    end
  end

  assign step_ready  = ready_reg;
  assign head_x      = head_reg.x;
  assign head_y      = head_reg.y;
  assign length      = len_reg;
  assign snake_x     = sx_reg;
  assign snake_y     = sy_reg;
  assign snake_dir   = sdir_reg;
  assign snake_first = sfirst_reg;
  assign snake_last  = slast_reg;
  assign snake_valid = svalid_reg;
  assign failure     = failure_reg;
  assign success     = success_reg;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Bench for snake_body_streamer: directed scenarios then random moves, checked against
// a coordinate-list model of the snake (head first) with its own move/collision rules.
module tb_snake_body_streamer;
  import snake_body_streamer_pkg::*;

  localparam int MAXL = 8;
  localparam int ILEN = 3;
  localparam int IX   = 4;
  localparam int IY   = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_valid = 1'b0;
  logic [1:0] step_dir = 2'd0;
  logic       step_grow = 1'b0;
  logic       step_ready, snake_first, snake_last, snake_valid, failure, success;
  logic [4:0] head_x, snake_x;
  logic [3:0] head_y, snake_y;
  logic [5:0] length;
  logic [1:0] snake_dir;

  int n_vec = 0;
  int n_bad = 0;
  int bx[$];
  int by[$];
  bit mfail, msucc;

  always #5 clk = ~clk;

  snake_body_streamer #(.MAX_LEN(MAXL), .INIT_LEN(ILEN), .INIT_X(IX), .INIT_Y(IY)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_dir(step_dir), .step_grow(step_grow),
    .step_ready(step_ready), .head_x(head_x), .head_y(head_y), .length(length),
    .snake_x(snake_x), .snake_y(snake_y), .snake_dir(snake_dir), .snake_first(snake_first),
    .snake_last(snake_last), .snake_valid(snake_valid), .failure(failure), .success(success)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Direction from body[k] toward body[k+1], from coordinate differences.
  function automatic int seg_dir_of(input int k);
    int dx, dy;
    dx = bx[k+1] - bx[k];
    dy = by[k+1] - by[k];
    if (dx == 1)  return 0;
    if (dx == -1) return 1;
    if (dy == 1)  return 2;
    return 3;
  endfunction

  function automatic void model_reset();
    bx.delete();
    by.delete();
    for (int i = 0; i < ILEN; i++) begin
      bx.push_back(IX - i);
      by.push_back(IY);
    end
    mfail = 0;
    msucc = 0;
  endfunction

  function automatic void model_step(input int dir_in, input bit grow);
    int d, heading, nx, ny, n;
    bit bad;
    n = bx.size();
    d = dir_in;
    heading = seg_dir_of(0) ^ 1;
    if (d == (heading ^ 1)) d = heading;
    nx = bx[0] + ((d == 0) ? 1 : 0) - ((d == 1) ? 1 : 0);
    ny = by[0] + ((d == 2) ? 1 : 0) - ((d == 3) ? 1 : 0);
    bad = (nx == 0) || (nx == GAME_WIDTH + 1) || (ny == 0) || (ny == GAME_HEIGHT + 1);
    for (int i = 0; i < n; i++)
      if (!(i == n - 1 && !grow) && bx[i] == nx && by[i] == ny) bad = 1;
    if (bad) begin
      mfail = 1;
    end else begin
      bx.push_front(nx);
      by.push_front(ny);
      if (!(grow && n < MAXL)) begin
        void'(bx.pop_back());
        void'(by.pop_back());
      end
      if (bx.size() == MAXL) msucc = 1;
    end
  endfunction

  task automatic check_state(input string tag);
    $display("state %s: head=(%0d,%0d) len=%0d ready=%0d fail=%0d succ=%0d",
             tag, head_x, head_y, length, step_ready, failure, success);
    chk({tag, ".head_x"}, 32'(head_x), bx[0]);
    chk({tag, ".head_y"}, 32'(head_y), by[0]);
    chk({tag, ".length"}, 32'(length), bx.size());
    chk({tag, ".failure"}, 32'(failure), 32'(mfail));
    chk({tag, ".success"}, 32'(success), 32'(msucc));
    chk({tag, ".ready"}, 32'(step_ready), 32'(!(mfail || msucc)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("reset.valid", 32'(snake_valid), 0);
    check_state("reset");
    rst = 1'b0;
  endtask

  // Finds the next head emission, checks one whole pass and the absence of a gap after it.
  task automatic check_pass(input string tag);
    int t, n;
    t = 0;
    while (!(snake_valid === 1'b1 && snake_first === 1'b1) && t < 4 * MAXL + 8) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".pass_start"}, 32'(snake_valid === 1'b1 && snake_first === 1'b1), 1);
    n = bx.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, ".valid"}, 32'(snake_valid), 1);
      chk({tag, ".x"}, 32'(snake_x), bx[k]);
      chk({tag, ".y"}, 32'(snake_y), by[k]);
      chk({tag, ".first"}, 32'(snake_first), 32'(k == 0));
      chk({tag, ".last"}, 32'(snake_last), 32'(k == n - 1));
      if (k < n - 1) chk({tag, ".dir"}, 32'(snake_dir), seg_dir_of(k));
      @(negedge clk);
    end
    chk({tag, ".no_gap"}, 32'(snake_valid && snake_first), 1);
    $display("pass %s: %0d segments, head=(%0d,%0d)", tag, n, bx[0], by[0]);
  endtask

  task automatic do_step(input string tag, input int d, input bit g);
    int t, nlen;
    t = 0;
    while (step_ready !== 1'b1 && t < 4 * MAXL + 8) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".ready_before"}, 32'(step_ready), 1);
    step_valid = 1'b1;
    step_dir   = 2'(d);
    step_grow  = g;
    @(negedge clk);
    step_valid = 1'b0;
    nlen = bx.size();
    model_step(d, g);
    t = 1;
    while (!(step_ready === 1'b1 || failure === 1'b1 || success === 1'b1) && t < 2 * nlen + 8) begin
      @(negedge clk);
      t++;
    end
    $display("step %s: dir=%0d grow=%0d latency=%0d", tag, d, g, t);
    chk({tag, ".latency_ok"}, 32'(t <= 2 * nlen + 2), 1);
    check_state(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t;

    // Reset stream, two back-to-back passes.
    do_reset();
    check_pass("reset_p1");
    check_pass("reset_p2");

    // Step up, no grow.
    do_step("up", 3, 0);
    check_pass("up_p");

    // Grow from reset.
    do_reset();
    do_step("right_grow", 0, 1);
    check_pass("grow_p");

    // Reversal replaced by current heading.
    do_reset();
    do_step("reverse", 1, 0);
    check_pass("reverse_p");

    // Walk into the left wall.
    do_reset();
    do_step("w1", 3, 0);
    do_step("w2", 1, 0);
    do_step("w3", 1, 0);
    do_step("w4", 1, 0);
    do_step("wall", 1, 0);
    repeat (2 * MAXL + 4) @(negedge clk);
    check_state("wall_hold");
    check_pass("wall_p");

    // Square of four: moving into the vacating tail is legal, with grow it is not.
    do_reset();
    do_step("sq1", 0, 1);
    do_step("sq2", 3, 0);
    do_step("sq3", 1, 0);
    do_step("tail_ok", 2, 0);
    check_pass("tail_ok_p");
    do_step("tail_grow", 0, 1);
    check_pass("tail_grow_p");

    // Grow up to MAX_LEN.
    do_reset();
    for (int i = 0; i < MAXL - ILEN; i++) do_step("fill", 0, 1);
    repeat (2 * MAXL + 4) @(negedge clk);
    check_state("full_hold");
    check_pass("full_p");

    // Reset asserted at the edge where the move would be applied.
    do_reset();
    t = 0;
    while (!(snake_valid === 1'b1 && snake_first === 1'b1) && t < 4 * MAXL) begin
      @(negedge clk);
      t++;
    end
    step_valid = 1'b1;
    step_dir   = 2'd3;
    step_grow  = 1'b0;
    @(negedge clk);
    step_valid = 1'b0;
    cnt = (snake_last === 1'b1) ? 1 : 0;
    t = 0;
    while (cnt < 2 && t < 6 * MAXL) begin
      @(negedge clk);
      t++;
      if (snake_last === 1'b1) cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_upd.valid", 32'(snake_valid), 0);
    check_state("rst_upd");
    rst = 1'b0;
    check_pass("rst_upd_p");

    // Random moves; restart whenever the game ends.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int d;
      bit g;
      if (mfail || msucc) do_reset();
      d = int'($urandom_range(0, 3));
      g = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_step("rand", d, g);
      if (i % 3 == 0) check_pass("rand_p");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
